// File: rtl/serial_seq_ctrl_if.sv
// Interface bundling the opcode/start handshake and the datapath control strobes.
// Optional macro SERIAL_STEP_EN adds the step_en throttle input.
interface serial_seq_ctrl_if #(
    parameter int DATA_W  = 8,
    parameter int DIGIT_W = 1
);
    localparam int STEPS = DATA_W / DIGIT_W;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic [3:0]       opcode;
    logic             btn_edge;
`ifdef SERIAL_STEP_EN
    logic             step_en;
`endif
    logic             busy;
    logic             load_a;
    logic             load_b;
    logic             shift_a;
    logic             shift_b;
    logic             shift_out;
    logic [1:0]       alu_op;
    logic             invert_b;
    logic             carry_in_set;
    logic             carry_en;
    logic             load_out;
    logic [CNT_W-1:0] step_idx;
    logic             done;
    logic             illegal;

    modport master (
        output opcode,
        output btn_edge,
`ifdef SERIAL_STEP_EN
        output step_en,
`endif
        input  busy,
        input  load_a,
        input  load_b,
        input  shift_a,
        input  shift_b,
        input  shift_out,
        input  alu_op,
        input  invert_b,
        input  carry_in_set,
        input  carry_en,
        input  load_out,
        input  step_idx,
        input  done,
        input  illegal
    );

    modport slave (
        input  opcode,
        input  btn_edge,
`ifdef SERIAL_STEP_EN
        input  step_en,
`endif
        output busy,
        output load_a,
        output load_b,
        output shift_a,
        output shift_b,
        output shift_out,
        output alu_op,
        output invert_b,
        output carry_in_set,
        output carry_en,
        output load_out,
        output step_idx,
        output done,
        output illegal
    );
endinterface

// File: rtl/serial_seq_ctrl.sv
// Sequencer for the bit/digit-serial datapath: load operands, run STEPS shift cycles, commit.
// Optional macro SERIAL_STEP_EN gates EXEC progress with bus.step_en.
module serial_seq_ctrl #(
    parameter int DATA_W  = 8,
    parameter int DIGIT_W = 1
) (
    input logic        clk,
    input logic        rstn,
    serial_seq_ctrl_if.slave bus
);
    localparam int STEPS = DATA_W / DIGIT_W;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_WRITE
    } state_t;

    state_t           state, next_state;
    logic [3:0]       op_q;
    logic [CNT_W-1:0] step_q, step_d;
    logic             illegal_q;
    logic [2:0]       ctrl_q;
    logic             start_legal;
    logic             advance;
    logic             is_sub;
    logic             is_arith;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b1000, 4'b0001, 4'b1001,
            4'b0110, 4'b1100, 4'b0101, 4'b1011,
            4'b0100, 4'b1010: op_legal = 1'b1;
            default:          op_legal = 1'b0;
        endcase
    endfunction

    // Returns {invert_b, alu_op[1:0]}.
    function automatic logic [2:0] op_ctrl(input logic [3:0] op);
        case (op)
            4'b0001, 4'b1001: op_ctrl = 3'b1_00;
            4'b0110, 4'b1100: op_ctrl = 3'b0_01;
            4'b0101, 4'b1011: op_ctrl = 3'b0_10;
            4'b0100, 4'b1010: op_ctrl = 3'b0_11;
            default:          op_ctrl = 3'b0_00;
        endcase
    endfunction

    assign start_legal = bus.btn_edge && op_legal(bus.opcode);
    assign ctrl_q      = op_ctrl(op_q);
    assign is_sub      = ctrl_q[2];
    assign is_arith    = (ctrl_q[1:0] == 2'b00);

`ifdef SERIAL_STEP_EN
    assign advance = bus.step_en;
`else
    assign advance = 1'b1;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            op_q      <= 4'd0;
            step_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= next_state;
            step_q    <= step_d;
            illegal_q <= (state == S_IDLE) && bus.btn_edge && !op_legal(bus.opcode);
            if ((state == S_IDLE) && start_legal) begin
                op_q <= bus.opcode;
            end
        end
    end

    always_comb begin
        next_state       = state;
        step_d           = step_q;
        bus.busy         = (state != S_IDLE);
        bus.load_a       = 1'b0;
        bus.load_b       = 1'b0;
        bus.shift_a      = 1'b0;
        bus.shift_b      = 1'b0;
        bus.shift_out    = 1'b0;
        bus.carry_in_set = 1'b0;
        bus.carry_en     = 1'b0;
        bus.load_out     = 1'b0;
        bus.done         = 1'b0;
        bus.illegal      = illegal_q;
        bus.step_idx     = step_q;
        bus.alu_op       = (state != S_IDLE) ? ctrl_q[1:0] : 2'b00;
        bus.invert_b     = (state != S_IDLE) ? ctrl_q[2] : 1'b0;

        case (state)
            S_IDLE: begin
                if (start_legal) begin
                    next_state = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                bus.load_a = 1'b1;
                next_state = op_q[3] ? S_LOAD_B : S_EXEC;
            end
            S_LOAD_B: begin
                bus.load_b = 1'b1;
                next_state = S_EXEC;
            end
            S_EXEC: begin
                if (advance) begin
                    bus.shift_a      = 1'b1;
                    bus.shift_b      = 1'b1;
                    bus.shift_out    = 1'b1;
                    bus.carry_in_set = is_sub && (step_q == '0);
                    bus.carry_en     = is_arith && (step_q != '0);
                    if (step_q == LAST_STEP) begin
                        step_d     = '0;
                        next_state = S_WRITE;
                    end else begin
                        step_d = step_q + CNT_W'(1);
                    end
                end
            end
            S_WRITE: begin
                bus.load_out = 1'b1;
                bus.done     = 1'b1;
                next_state   = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_serial_seq_ctrl.sv
// Scoreboard bench: a bit-serial (DIGIT_W=1) and a digit-serial (DIGIT_W=4) sequencer
// share stimulus; each has a timeline model that predicts every output cycle by cycle.
module tb_serial_seq_ctrl;
    localparam int DATA_W = 8;

    logic        clk      = 1'b0;
    logic        rstn     = 1'b0;
    logic [3:0]  opcode   = 4'd0;
    logic        btn_edge = 1'b0;
    int          checks   = 0;
    int          errors   = 0;
    int unsigned edge_cnt = 0;

    typedef struct {
        bit          is_illegal;
        int unsigned acc;
        int unsigned due;
        bit          rtype;
        bit          sub;
        bit          arith;
        logic [1:0]  alu;
    } exp_t;

    always #5 clk = ~clk;

    // Clock-edge counter; NBA update so every process reads a consistent value per cycle.
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Operation class from the opcode table: 0 add, 1 sub, 2 xor, 3 and, 4 or, -1 illegal.
    function automatic int op_kind(input logic [3:0] op);
        case (op)
            4'd0, 4'd8:  return 0;
            4'd1, 4'd9:  return 1;
            4'd6, 4'd12: return 2;
            4'd5, 4'd11: return 3;
            4'd4, 4'd10: return 4;
            default:     return -1;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at edge %0d", name, actual, expected, edge_cnt);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int DW    = (g == 0) ? 1 : 4;
        localparam int STEPS = DATA_W / DW;

        serial_seq_ctrl_if #(.DATA_W(DATA_W), .DIGIT_W(DW)) bus ();

        assign bus.opcode   = opcode;
        assign bus.btn_edge = btn_edge;
`ifdef SERIAL_STEP_EN
        assign bus.step_en  = 1'b1;
`endif

        serial_seq_ctrl #(.DATA_W(DATA_W), .DIGIT_W(DW)) dut (
            .clk  (clk),
            .rstn (rstn),
            .bus  (bus)
        );

        logic [31:0] outs;
        assign outs = {bus.busy, bus.load_a, bus.load_b, bus.shift_a, bus.shift_b, bus.shift_out,
                       bus.alu_op, bus.invert_b, bus.carry_in_set, bus.carry_en, bus.load_out,
                       bus.done, bus.illegal, 18'(bus.step_idx)};

        exp_t        q[$];
        int unsigned free_at = 0;
        int          pending = 0;

        // Reference model: records each accepted start with its completion time.
        always @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                q.delete();
                free_at = 0;
            end else if (btn_edge && edge_cnt >= free_at) begin
                exp_t e;
                int   k;
                k            = op_kind(opcode);
                e.acc        = edge_cnt;
                e.rtype      = opcode[3];
                e.is_illegal = (k < 0);
                e.sub        = (k == 1);
                e.arith      = (k == 0) || (k == 1);
                e.alu        = (k <= 1) ? 2'd0 : 2'(k - 1);
                if (k < 0) begin
                    e.due = edge_cnt + 1;
                end else begin
                    e.due   = edge_cnt + STEPS + (e.rtype ? 3 : 2);
                    free_at = e.due + 1;
                end
                q.push_back(e);
            end
        end

        // Expected outputs for the cycle whose edge count is 'now', from the timelines in flight.
        function automatic logic [31:0] expect_vec(input int unsigned now);
            logic       bsy, la, lb, sh, inv, cis, ce, fin, ill;
            logic [1:0] alu;
            int         step, rel, xs;
            {bsy, la, lb, sh, inv, cis, ce, fin, ill} = '0;
            alu  = 2'd0;
            step = 0;
            foreach (q[i]) begin
                if (q[i].is_illegal) begin
                    if (now == q[i].due) ill = 1'b1;
                end else if (now > q[i].acc && now <= q[i].due) begin
                    bsy = 1'b1;
                    alu = q[i].alu;
                    inv = q[i].sub;
                    rel = int'(now - q[i].acc);
                    xs  = q[i].rtype ? 3 : 2;
                    if (rel == 1) la = 1'b1;
                    if (q[i].rtype && rel == 2) lb = 1'b1;
                    if (rel >= xs && rel < xs + STEPS) begin
                        sh   = 1'b1;
                        step = rel - xs;
                        cis  = q[i].sub && (step == 0);
                        ce   = q[i].arith && (step > 0);
                    end
                    if (now == q[i].due) fin = 1'b1;
                end
            end
            return {bsy, la, lb, sh, sh, sh, alu, inv, cis, ce, fin, fin, ill, 18'(step)};
        endfunction

        // Monitor: full-vector check every cycle, then pop the scoreboard on done/illegal.
        always @(negedge clk) begin
            exp_t e;
            checkOutput($sformatf("dw%0d_outputs", DW), outs, expect_vec(edge_cnt));
            if (rstn) begin
                while (q.size() > 0 && q[0].due < edge_cnt) begin
                    e = q.pop_front();
                    checkOutput($sformatf("dw%0d_missing_response", DW), 32'd0, 32'd1);
                end
                if (outs[19] || outs[18]) begin
                    if (q.size() == 0) begin
                        checkOutput($sformatf("dw%0d_unexpected_response", DW), outs, 32'd0);
                    end else begin
                        e = q.pop_front();
                        checkOutput($sformatf("dw%0d_resp_time", DW), edge_cnt, e.due);
                        checkOutput($sformatf("dw%0d_resp_kind", DW), 32'(outs[18]), 32'(e.is_illegal));
                    end
                end
            end
            pending = q.size();
        end
    end

    task automatic applyStimulus(input logic [3:0] op, input logic pulse);
        @(posedge clk);
        #2;
        opcode   = op;
        btn_edge = pulse;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(4'($urandom_range(15, 0)), 1'b0);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        applyStimulus(opcode, 1'b0);
        while ((inst[0].outs[31] || inst[1].outs[31]) && n < 100) begin
            applyStimulus(opcode, 1'b0);
            n++;
        end
        if (n >= 100) checkOutput("idle_timeout", 32'd1, 32'd0);
        idleCycles(2);
    endtask

    initial begin
        logic [3:0] legal_ops [10];
        legal_ops = '{4'd0, 4'd8, 4'd1, 4'd9, 4'd6, 4'd12, 4'd5, 4'd11, 4'd4, 4'd10};

        repeat (3) @(posedge clk);
        #3;
        checkOutput("reset_dw1", inst[0].outs, 32'd0);
        checkOutput("reset_dw4", inst[1].outs, 32'd0);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        idleCycles(2);

        // Directed: ADD, SUBI, XOR, illegal.
        applyStimulus(4'b1000, 1'b1); waitIdle();
        applyStimulus(4'b0001, 1'b1); waitIdle();
        applyStimulus(4'b1100, 1'b1); waitIdle();
        applyStimulus(4'b1111, 1'b1); waitIdle();

        // Repeated starts while busy are dropped; a start after done begins a fresh instruction.
        applyStimulus(4'b1000, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(4'b0110, 1'b1);
        waitIdle();
        applyStimulus(4'b1011, 1'b1); waitIdle();

        // Reset while the bit-serial instance is at EXEC step 3.
        applyStimulus(4'b1000, 1'b1);
        idleCycles(5);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        btn_edge = 1'b0;
        #1;
        checkOutput("midexec_reset_dw1", inst[0].outs, 32'd0);
        checkOutput("midexec_reset_dw4", inst[1].outs, 32'd0);
        idleCycles(2);
        rstn = 1'b1;
        idleCycles(1);
        applyStimulus(4'b1001, 1'b1); waitIdle();

        // Randomized traffic, mostly legal opcodes, occasional reset.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] op;
            if ($urandom_range(9, 0) < 8) op = legal_ops[$urandom_range(9, 0)];
            else                          op = 4'($urandom_range(15, 0));
            applyStimulus(op, ($urandom_range(2, 0) == 0));
            if ($urandom_range(199, 0) == 0) begin
                rstn = 1'b0;
                idleCycles(1);
                rstn = 1'b1;
            end
        end
        waitIdle();
        idleCycles(3);
        checkOutput("drain_dw1", 32'(inst[0].pending), 32'd0);
        checkOutput("drain_dw4", 32'(inst[1].pending), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
